// File: rtl/elastic_config_loader_pkg.sv
// Shared parameters and types for the elastic PE-array configuration loader.
// ElasticConfigData is the broadcast bus format seen by every PE.
package elastic_config_loader_pkg;

   localparam int DATA_WIDTH              = 16;
   localparam int OPERATION_BIT_LENGTH    = 4;
   localparam int INPUT_NUM_BIT_LENGTH    = 3;
   localparam int NEIGHBOR_PE_NUM         = 4;
   localparam int CONTEXT_SIZE_BIT_LENGTH = 4;
   // Entry PE ids are widened to this before decoding so the struct stays
   // independent of the per-instance PE_ID_WIDTH.
   localparam int ENTRY_PE_ID_W           = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_RUN
   } loader_state_t;

   typedef struct packed {
      logic [CONTEXT_SIZE_BIT_LENGTH-1:0] index;
      logic [INPUT_NUM_BIT_LENGTH-1:0]    in1;
      logic [INPUT_NUM_BIT_LENGTH-1:0]    in2;
      logic [NEIGHBOR_PE_NUM-1:0]         out_mask;
      logic [OPERATION_BIT_LENGTH-1:0]    op;
      logic [DATA_WIDTH-1:0]              const_data;
   } ElasticConfigData;

   typedef struct packed {
      logic [ENTRY_PE_ID_W-1:0] pe_id;
      ElasticConfigData         cfg;
   } config_entry_t;

endpackage

// File: rtl/elastic_config_loader_decoder.sv
// PE id to one-hot write strobe; ids at or above PE_NUM decode to all-zero.
module elastic_config_decoder
   import elastic_config_loader_pkg::*;
#(
   parameter int PE_NUM = 16
) (
   input  logic [ENTRY_PE_ID_W-1:0] i_pe_id,
   output logic [PE_NUM-1:0]        o_strobe,
   output logic                     o_in_range
);

   assign o_in_range = (i_pe_id < ENTRY_PE_ID_W'(PE_NUM));

   for (genvar g = 0; g < PE_NUM; g++) begin : g_strobe
      assign o_strobe[g] = o_in_range && (i_pe_id == ENTRY_PE_ID_W'(g));
   end

endmodule

// File: rtl/elastic_config_loader.sv
// Accepts a counted stream of config entries, broadcasts each to the PE array
// with a one-hot write strobe, then pulses start_exec once the load completes.
module elastic_config_loader
   import elastic_config_loader_pkg::*;
#(
   parameter int PE_NUM      = 16,
   parameter int PE_ID_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               load_start,
   input  logic [15:0]                        load_entry_count,
   input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_context_max_id,
   input  logic                               exec_abort,
   input  logic [PE_ID_WIDTH-1:0]             entry_pe_id,
   input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] entry_context,
   input  logic [INPUT_NUM_BIT_LENGTH-1:0]    entry_in1,
   input  logic [INPUT_NUM_BIT_LENGTH-1:0]    entry_in2,
   input  logic [NEIGHBOR_PE_NUM-1:0]         entry_out_mask,
   input  logic [OPERATION_BIT_LENGTH-1:0]    entry_op,
   input  logic [DATA_WIDTH-1:0]              entry_const,
   input  logic                               valid_input,
   output logic                               stop_input,
   output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
   output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
   output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
   output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
   output logic [DATA_WIDTH-1:0]              config_const_data,
   output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
   output logic [PE_NUM-1:0]                  write_config_data,
   output logic                               start_exec,
   output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
   output logic                               busy,
   output logic                               load_error
);

   loader_state_t                      r_state;
   logic [15:0]                        r_count;
   logic [15:0]                        r_acc;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_max;
   ElasticConfigData                   r_cfg;
   logic [PE_NUM-1:0]                  r_wr;
   logic                               r_stop;
   logic                               r_start;
   logic                               r_busy;
   logic                               r_err;

   config_entry_t     w_entry;
   logic [PE_NUM-1:0] w_onehot;
   logic              w_in_range;
   logic              w_xfer;
   logic              w_reload;
   logic              w_entry_ok;
   logic              w_last;

   assign w_entry = '{
      pe_id: ENTRY_PE_ID_W'(entry_pe_id),
      cfg:   '{index: entry_context, in1: entry_in1, in2: entry_in2,
               out_mask: entry_out_mask, op: entry_op, const_data: entry_const}
   };

   elastic_config_decoder #(.PE_NUM(PE_NUM)) u_dec (
      .i_pe_id    (w_entry.pe_id),
      .o_strobe   (w_onehot),
      .o_in_range (w_in_range)
   );

   assign w_xfer     = valid_input && !r_stop && (r_state == ST_LOAD);
   assign w_entry_ok = w_in_range && (entry_context <= r_max);
   // r_acc < r_count holds in LOAD, so the increment never wraps.
   assign w_last     = ((r_acc + 16'd1) == r_count);
   assign w_reload   = load_start && ((r_state == ST_IDLE) || (r_state == ST_RUN));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_acc   <= '0;
         r_max   <= '0;
         r_cfg   <= '0;
         r_wr    <= '0;
         r_stop  <= 1'b1;
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_wr    <= '0;
         r_start <= 1'b0;
         if (w_reload) begin
            r_count <= load_entry_count;
            r_max   <= load_context_max_id;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            if (load_entry_count == 16'd0) begin
               r_state <= ST_START;
            end else begin
               r_state <= ST_LOAD;
               r_stop  <= 1'b0;
            end
         end else begin
            case (r_state)
               ST_LOAD: begin
                  if (w_xfer) begin
                     r_cfg <= w_entry.cfg;
                     r_acc <= r_acc + 16'd1;
                     if (w_entry_ok) r_wr  <= w_onehot;
                     else            r_err <= 1'b1;
                     if (w_last) begin
                        r_state <= ST_START;
                        r_stop  <= 1'b1;
                     end
                  end
               end
               ST_START: begin
                  r_start <= 1'b1;
                  r_state <= ST_RUN;
               end
               ST_RUN: begin
                  if (exec_abort) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign stop_input              = r_stop;
   assign write_config_data       = r_wr;
   assign start_exec              = r_start;
   assign busy                    = r_busy;
   assign load_error              = r_err;
   assign mapping_context_max_id  = r_max;
   assign config_index            = r_cfg.index;
   assign config_input_PE_index_1 = r_cfg.in1;
   assign config_input_PE_index_2 = r_cfg.in2;
   assign config_output_PE_index  = r_cfg.out_mask;
   assign config_op               = r_cfg.op;
   assign config_const_data       = r_cfg.const_data;

endmodule

// File: tb/tb_elastic_config_loader.sv
// Directed plus randomized bench for elastic_config_loader, checked every cycle
// against a transaction-level model of the load/start/run protocol.
module tb_elastic_config_loader;
   import elastic_config_loader_pkg::*;

   localparam int PE_NUM      = 8;
   localparam int PE_ID_WIDTH = 4;
   localparam int CW          = CONTEXT_SIZE_BIT_LENGTH;

   logic                            clk = 1'b0;
   logic                            reset = 1'b1;
   logic                            load_start = 1'b0;
   logic [15:0]                     load_entry_count = '0;
   logic [CW-1:0]                   load_context_max_id = '0;
   logic                            exec_abort = 1'b0;
   logic [PE_ID_WIDTH-1:0]          entry_pe_id = '0;
   logic [CW-1:0]                   entry_context = '0;
   logic [INPUT_NUM_BIT_LENGTH-1:0] entry_in1 = '0;
   logic [INPUT_NUM_BIT_LENGTH-1:0] entry_in2 = '0;
   logic [NEIGHBOR_PE_NUM-1:0]      entry_out_mask = '0;
   logic [OPERATION_BIT_LENGTH-1:0] entry_op = '0;
   logic [DATA_WIDTH-1:0]           entry_const = '0;
   logic                            valid_input = 1'b0;

   logic                            stop_input;
   logic [INPUT_NUM_BIT_LENGTH-1:0] config_input_PE_index_1;
   logic [INPUT_NUM_BIT_LENGTH-1:0] config_input_PE_index_2;
   logic [NEIGHBOR_PE_NUM-1:0]      config_output_PE_index;
   logic [OPERATION_BIT_LENGTH-1:0] config_op;
   logic [DATA_WIDTH-1:0]           config_const_data;
   logic [CW-1:0]                   config_index;
   logic [PE_NUM-1:0]               write_config_data;
   logic                            start_exec;
   logic [CW-1:0]                   mapping_context_max_id;
   logic                            busy;
   logic                            load_error;

   int checks = 0;
   int failures = 0;

   // Model: phase 0 idle, 1 taking entries, 2 start pending, 3 running.
   int          m_phase = 0;
   int          m_left = 0;
   int          m_max = 0;
   bit          m_err = 0;
   logic [63:0] m_bus = '0;

   always #5 clk = ~clk;

   elastic_config_loader #(.PE_NUM(PE_NUM), .PE_ID_WIDTH(PE_ID_WIDTH)) dut (
      .clk(clk), .reset(reset), .load_start(load_start),
      .load_entry_count(load_entry_count), .load_context_max_id(load_context_max_id),
      .exec_abort(exec_abort), .entry_pe_id(entry_pe_id), .entry_context(entry_context),
      .entry_in1(entry_in1), .entry_in2(entry_in2), .entry_out_mask(entry_out_mask),
      .entry_op(entry_op), .entry_const(entry_const), .valid_input(valid_input),
      .stop_input(stop_input), .config_input_PE_index_1(config_input_PE_index_1),
      .config_input_PE_index_2(config_input_PE_index_2),
      .config_output_PE_index(config_output_PE_index), .config_op(config_op),
      .config_const_data(config_const_data), .config_index(config_index),
      .write_config_data(write_config_data), .start_exec(start_exec),
      .mapping_context_max_id(mapping_context_max_id), .busy(busy), .load_error(load_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock: derive expected post-edge outputs from current inputs, then compare.
   task automatic cycle();
      logic [63:0] wr = '0;
      bit          st = 1'b0;
      if (reset) begin
         m_phase = 0; m_left = 0; m_max = 0; m_err = 0; m_bus = '0;
      end else if (load_start && (m_phase == 0 || m_phase == 3)) begin
         m_left  = int'(load_entry_count);
         m_max   = int'(load_context_max_id);
         m_err   = 0;
         m_phase = (load_entry_count == 0) ? 2 : 1;
      end else if (m_phase == 1) begin
         if (valid_input) begin
            m_bus = 64'({entry_context, entry_in1, entry_in2, entry_out_mask, entry_op, entry_const});
            if (int'(entry_pe_id) < PE_NUM && int'(entry_context) <= m_max)
               wr = 64'd1 << entry_pe_id;
            else
               m_err = 1;
            m_left--;
            if (m_left == 0) m_phase = 2;
         end
      end else if (m_phase == 2) begin
         st = 1'b1;
         m_phase = 3;
      end else if (m_phase == 3 && exec_abort) begin
         m_phase = 0;
      end
      @(posedge clk);
      #1;
      chk("write_config_data", 64'(write_config_data), wr);
      chk("start_exec", 64'(start_exec), 64'(st));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("stop_input", 64'(stop_input), 64'(m_phase != 1));
      chk("load_error", 64'(load_error), 64'(m_err));
      chk("mapping_context_max_id", 64'(mapping_context_max_id), 64'(m_max));
      chk("config_bus", 64'({config_index, config_input_PE_index_1, config_input_PE_index_2,
                             config_output_PE_index, config_op, config_const_data}), m_bus);
   endtask

   task automatic rand_entry(input int pe_hi, input int ctx_hi);
      entry_pe_id    = PE_ID_WIDTH'($urandom_range(0, pe_hi));
      entry_context  = CW'($urandom_range(0, ctx_hi));
      entry_in1      = INPUT_NUM_BIT_LENGTH'($urandom);
      entry_in2      = INPUT_NUM_BIT_LENGTH'($urandom);
      entry_out_mask = NEIGHBOR_PE_NUM'($urandom);
      entry_op       = OPERATION_BIT_LENGTH'($urandom);
      entry_const    = DATA_WIDTH'($urandom);
   endtask

   task automatic start_load(input int cnt, input int maxid);
      load_start = 1'b1;
      load_entry_count = 16'(cnt);
      load_context_max_id = CW'(maxid);
      cycle();
      load_start = 1'b0;
   endtask

   initial begin
      // Reset state
      cycle(); cycle();
      reset = 1'b0;
      cycle();

      // Three back-to-back entries to PEs 0,1,2, then start and abort from RUN
      start_load(3, 2);
      for (int i = 0; i < 3; i++) begin
         valid_input = 1'b1;
         rand_entry(7, 2);
         entry_pe_id = PE_ID_WIDTH'(i);
         cycle();
      end
      valid_input = 1'b0;
      repeat (3) cycle();
      exec_abort = 1'b1; cycle(); exec_abort = 1'b0; cycle();

      // Gapped valid; extra valid after the last transfer must be refused
      start_load(2, 15);
      valid_input = 1'b1; rand_entry(7, 15); cycle();
      valid_input = 1'b0; cycle();
      valid_input = 1'b1; rand_entry(7, 15); cycle();
      rand_entry(7, 15); cycle();
      valid_input = 1'b0;
      repeat (2) cycle();
      exec_abort = 1'b1; cycle(); exec_abort = 1'b0;

      // Out-of-range PE id and over-limit context both flag an error
      start_load(3, 3);
      valid_input = 1'b1;
      rand_entry(7, 3); entry_pe_id = 4'd15; cycle();
      rand_entry(7, 3); entry_context = CW'(5); cycle();
      rand_entry(7, 3); cycle();
      valid_input = 1'b0;
      repeat (3) cycle();

      // Reload from RUN with an empty load, then reload again with one entry
      start_load(0, 6);
      repeat (3) cycle();
      start_load(1, 1);
      valid_input = 1'b1; rand_entry(7, 1); cycle();
      valid_input = 1'b0; repeat (3) cycle();
      exec_abort = 1'b1; cycle(); exec_abort = 1'b0;

      // Reset mid-load, then a fresh single-entry load
      start_load(4, 9);
      valid_input = 1'b1; rand_entry(7, 9); cycle();
      rand_entry(7, 9); reset = 1'b1; cycle();
      reset = 1'b0; cycle();
      valid_input = 1'b0; cycle();
      start_load(1, 9);
      valid_input = 1'b1; rand_entry(7, 9); cycle();
      valid_input = 1'b0; repeat (3) cycle();
      exec_abort = 1'b1; cycle(); exec_abort = 1'b0;

      // load_start and exec_abort during LOAD are ignored
      start_load(3, 15);
      load_start = 1'b1; load_entry_count = 16'd1; exec_abort = 1'b1; cycle();
      load_start = 1'b0; exec_abort = 1'b0;
      valid_input = 1'b1;
      repeat (3) begin rand_entry(7, 15); cycle(); end
      valid_input = 1'b0; load_start = 1'b1; cycle(); load_start = 1'b0;
      repeat (2) cycle();
      exec_abort = 1'b1; cycle(); exec_abort = 1'b0;

      // Maximum count keeps accepting without an early end
      start_load(16'hFFFF, 15);
      valid_input = 1'b1;
      repeat (300) begin rand_entry(15, 15); cycle(); end
      valid_input = 1'b0;
      reset = 1'b1; cycle(); reset = 1'b0; cycle();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         reset       = ($urandom_range(0, 99) == 0);
         load_start  = ($urandom_range(0, 9) == 0);
         load_entry_count    = 16'($urandom_range(0, 6));
         load_context_max_id = CW'($urandom);
         exec_abort  = ($urandom_range(0, 7) == 0);
         valid_input = $urandom_range(0, 1) == 1;
         rand_entry(15, 15);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
